uart_tx_drain_ctrl: RTL and testbench

- Read-side sequencer for the TX async FIFO feeding the UART transmitter.
- Watches the FIFO empty flag, issues single-cycle read enables and waits out the block-RAM read latency.
- Captures each DATA_W-bit word and serialises it LSB-byte-first into the UART TX byte handshake.
- Sits entirely in the FIFO read clock domain, between the FIFO read-pointer logic / BRAM and the UART TX core.

---
 rtl/uart_ddr_pkg.sv | 16 +
 rtl/word_byte_serializer.sv | 50 +++++
 rtl/uart_tx_drain_ctrl.sv | 97 +++++++++
 tb/tb_uart_tx_drain_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_ddr_pkg.sv
// Shared definitions for the UART TX drain sequencer and the matching RX packer.
package uart_ddr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_WAIT = 3'd2,
    ST_LOAD = 3'd3,
    ST_SEND = 3'd4
  } drain_state_e;

  function automatic int bytes_per_word(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/word_byte_serializer.sv
// Holds one FIFO word and hands it to the UART byte handshake LSB byte first.
// Handshake: a byte transfers on a rising edge where tx_valid && tx_ready; while
// tx_valid is high and tx_ready is low, tx_byte and tx_valid are held unchanged.
module word_byte_serializer
  import uart_ddr_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              tx_ready,
  output logic [7:0]        tx_byte,
  output logic              tx_valid,
  output logic              last_accept
);

  localparam int         BPW      = bytes_per_word(DATA_W);
  localparam logic [3:0] LAST_IDX = 4'(BPW - 1);

  logic [DATA_W-1:0] shreg;
  logic [3:0]        idx;
  logic              accept;

  assign accept      = tx_valid && tx_ready;
  assign last_accept = accept && (idx == LAST_IDX);
  assign tx_byte     = shreg[7:0];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      shreg    <= '0;
      idx      <= '0;
      tx_valid <= 1'b0;
    end else if (load) begin
      shreg    <= load_data;
      idx      <= '0;
      tx_valid <= 1'b1;
    end else if (accept) begin
      // Last byte leaves the shift register as-is; only valid drops.
      if (idx == LAST_IDX) begin
        tx_valid <= 1'b0;
      end else begin
        shreg <= shreg >> 8;
        idx   <= idx + 4'd1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_drain_ctrl.sv
// Read-side sequencer: pulls words from the TX async FIFO one at a time, waits out
// the BRAM latency and feeds the bytes to the UART TX core.
module uart_tx_drain_ctrl
  import uart_ddr_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 16
) (
  input  logic              i_rd_clk,
  input  logic              i_rd_rstn,
  input  logic              i_enable,
  input  logic              i_empty,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic              o_rd_en,
  output logic [7:0]        o_tx_byte,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic              o_busy,
  output logic [CNT_W-1:0]  o_words_sent,
  output logic [2:0]        o_state
);

  drain_state_e state;
  logic [1:0]   wait_cnt;
  logic         fetch;
  logic         load;
  logic         last_accept;

  // Empty is only trusted in IDLE and at last-byte acceptance, both far enough
  // after the previous read for the registered flag to have caught up.
  assign fetch   = i_enable && !i_empty;
  assign load    = (state == ST_LOAD);
  assign o_state = state;

  always_ff @(posedge i_rd_clk) begin
    if (!i_rd_rstn) begin
      state        <= ST_IDLE;
      o_rd_en      <= 1'b0;
      o_busy       <= 1'b0;
      o_words_sent <= '0;
      wait_cnt     <= '0;
    end else begin
      o_rd_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (fetch) begin
            state   <= ST_READ;
            o_rd_en <= 1'b1;
            o_busy  <= 1'b1;
          end
        end
        ST_READ: begin
          state    <= ST_WAIT;
          wait_cnt <= 2'(RD_LAT - 1);
        end
        ST_WAIT: begin
          if (wait_cnt == 2'd0) state <= ST_LOAD;
          else                  wait_cnt <= wait_cnt - 2'd1;
        end
        ST_LOAD: begin
          state <= ST_SEND;
        end
        ST_SEND: begin
          if (last_accept) begin
            o_words_sent <= o_words_sent + 1'b1;
            if (fetch) begin
              state   <= ST_READ;
              o_rd_en <= 1'b1;
            end else begin
              state  <= ST_IDLE;
              o_busy <= 1'b0;
            end
          end
        end
        default: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

  word_byte_serializer #(
    .DATA_W(DATA_W)
  ) u_ser (
    .clk        (i_rd_clk),
    .rstn       (i_rd_rstn),
    .load       (load),
    .load_data  (i_rd_data),
    .tx_ready   (i_tx_ready),
    .tx_byte    (o_tx_byte),
    .tx_valid   (o_tx_valid),
    .last_accept(last_accept)
  );

endmodule

// File: tb/tb_uart_tx_drain_ctrl.sv
// Bench for uart_tx_drain_ctrl: FIFO/BRAM model, expected byte queue and word count.
module tb_uart_tx_drain_ctrl;
  localparam int DATA_W = 32;
  localparam int RD_LAT = 1;
  localparam int CNT_W  = 4;
  localparam int BPW    = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rstn;
  logic              enable;
  logic              empty;
  logic [DATA_W-1:0] rd_data;
  logic              rd_en;
  logic [7:0]        tx_byte;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;
  logic [CNT_W-1:0]  words_sent;
  logic [2:0]        state;

  always #5 clk = ~clk;

  uart_tx_drain_ctrl #(.DATA_W(DATA_W), .RD_LAT(RD_LAT), .CNT_W(CNT_W)) dut (
    .i_rd_clk    (clk),
    .i_rd_rstn   (rstn),
    .i_enable    (enable),
    .i_empty     (empty),
    .i_rd_data   (rd_data),
    .o_rd_en     (rd_en),
    .o_tx_byte   (tx_byte),
    .o_tx_valid  (tx_valid),
    .i_tx_ready  (tx_ready),
    .o_busy      (busy),
    .o_words_sent(words_sent),
    .o_state     (state)
  );

  int tests = 0;
  int fails = 0;

  logic [DATA_W-1:0] fifo_q[$];
  logic [7:0]        exp_q[$];
  int                rd_cyc_q[$];
  int                xfer_cyc_q[$];
  logic [CNT_W-1:0]  exp_words = '0;
  int                bytes_in_word = 0;
  int                cyc = 0;
  int                last_rd_cyc = 0;
  int                xfer_count = 0;
  int                rd_count = 0;
  logic              pend = 1'b0;
  logic [DATA_W-1:0] pend_word = '0;
  logic              prev_valid = 1'b0;
  logic              prev_ready = 1'b0;
  logic              prev_rstn = 1'b0;
  logic              prev_enable = 1'b0;
  logic              prev_rd = 1'b0;
  logic [7:0]        prev_byte = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs at a falling edge with the inputs for the coming rising edge already set.
  task automatic monitor();
    logic [DATA_W-1:0] w;
    cyc++;
    check("words_sent", words_sent, exp_words);
    if (pend) begin
      rd_data = pend_word;
      pend    = 1'b0;
    end
    if (prev_rstn && prev_valid && !prev_ready) begin
      check("hold_valid", tx_valid, 1);
      check("hold_byte", tx_byte, prev_byte);
    end
    if (prev_rstn && tx_valid && !prev_valid)
      check("first_valid_latency", cyc - last_rd_cyc, RD_LAT + 2);
    if (rstn && tx_valid && tx_ready) begin
      check("xfer_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check("tx_byte", tx_byte, exp_q.pop_front());
      xfer_count++;
      xfer_cyc_q.push_back(cyc);
      bytes_in_word++;
      if (bytes_in_word == BPW) begin
        bytes_in_word = 0;
        exp_words++;
      end
    end
    if (rstn && rd_en) begin
      check("rd_single_pulse", prev_rd, 0);
      check("rd_while_enabled", prev_enable, 1);
      check("rd_not_empty", fifo_q.size() > 0, 1);
      if (fifo_q.size() > 0) begin
        w = fifo_q.pop_front();
        for (int b = 0; b < BPW; b++) exp_q.push_back(w[8*b +: 8]);
        pend      = 1'b1;
        pend_word = w;
      end
      rd_data     = $urandom;
      empty       = (fifo_q.size() == 0);
      rd_count++;
      rd_cyc_q.push_back(cyc);
      last_rd_cyc = cyc;
    end
    if (!rstn) begin
      exp_q.delete();
      exp_words     = '0;
      bytes_in_word = 0;
      pend          = 1'b0;
    end
    prev_valid  = tx_valid;
    prev_ready  = tx_ready;
    prev_byte   = tx_byte;
    prev_rstn   = rstn;
    prev_enable = enable;
    prev_rd     = rd_en;
  endtask

  task automatic tick();
    monitor();
    @(negedge clk);
  endtask

  task automatic push_word(input logic [DATA_W-1:0] w);
    fifo_q.push_back(w);
    empty = 1'b0;
  endtask

  task automatic run_until_idle(input int budget, input bit rand_ready);
    bit done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (fifo_q.size() == 0 && !pend && exp_q.size() == 0 && !busy) begin
        done = 1'b1;
        break;
      end
      if (rand_ready) tx_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    check("idle_timeout", done, 1);
    tx_ready = 1'b1;
  endtask

  initial begin
    int  r0;
    int  x0;
    int  n;
    bit  found;

    rstn = 1'b0; enable = 1'b0; empty = 1'b1; rd_data = '0; tx_ready = 1'b1;
    @(negedge clk);
    tick();
    tick();
    rstn = 1'b1;
    tick();
    check("rst_valid", tx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_byte", tx_byte, 0);
    check("rst_words", words_sent, 0);
    check("rst_state", state, 0);

    // Single word, ready always high.
    enable = 1'b1;
    r0 = rd_count; x0 = xfer_count;
    push_word(32'hA1B2C3D4);
    run_until_idle(50, 1'b0);
    check("single_rd_pulses", rd_count - r0, 1);
    check("single_xfers", xfer_count - x0, 4);
    n = xfer_cyc_q.size();
    check("single_back_to_back", xfer_cyc_q[n-1] - xfer_cyc_q[n-4], 3);
    check("single_words", words_sent, 1);
    check("single_idle", state, 0);

    // Backpressure on byte 0xB2.
    x0 = xfer_count;
    push_word(32'hA1B2C3D4);
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (tx_valid && tx_byte == 8'hB2) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("bp_reach_b2", found, 1);
    tx_ready = 1'b0;
    repeat (5) tick();
    check("bp_b2_held", tx_byte, 8'hB2);
    check("bp_valid_held", tx_valid, 1);
    tx_ready = 1'b1;
    run_until_idle(50, 1'b0);
    check("bp_xfers", xfer_count - x0, 4);
    check("bp_words", words_sent, 2);

    // Three words back to back.
    r0 = rd_count;
    for (int i = 0; i < 3; i++) push_word($urandom);
    run_until_idle(100, 1'b0);
    check("b2b_rd_pulses", rd_count - r0, 3);
    n = rd_cyc_q.size();
    check("b2b_spacing_1", rd_cyc_q[n-2] - rd_cyc_q[n-3], 7);
    check("b2b_spacing_2", rd_cyc_q[n-1] - rd_cyc_q[n-2], 7);
    check("b2b_words", words_sent, 5);

    // Enable dropped during word 2 of 3.
    r0 = rd_count; x0 = xfer_count;
    for (int i = 0; i < 3; i++) push_word($urandom);
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (xfer_count - x0 >= 5) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("en_reach_word2", found, 1);
    enable = 1'b0;
    repeat (25) tick();
    check("en_off_rd_pulses", rd_count - r0, 2);
    check("en_off_words", words_sent, 7);
    check("en_off_busy", busy, 0);
    check("en_off_fifo_left", fifo_q.size(), 1);
    enable = 1'b1;
    run_until_idle(60, 1'b0);
    check("en_on_rd_pulses", rd_count - r0, 3);
    check("en_on_words", words_sent, 8);

    // Random ready pattern, then the counter wrap 15 -> 0 -> 1.
    for (int i = 0; i < 5; i++) push_word($urandom);
    run_until_idle(400, 1'b1);
    check("rand_words", words_sent, 13);
    push_word($urandom);
    run_until_idle(100, 1'b1);
    push_word($urandom);
    run_until_idle(100, 1'b1);
    check("wrap_15", words_sent, 15);
    push_word($urandom);
    run_until_idle(100, 1'b1);
    check("wrap_0", words_sent, 0);
    push_word($urandom);
    run_until_idle(100, 1'b1);
    check("wrap_1", words_sent, 1);

    // Reset after byte 1 of a word has been accepted.
    x0 = xfer_count;
    push_word(32'hA1B2C3D4);
    push_word($urandom);
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (xfer_count - x0 == 2) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("rstmid_reach_byte1", found, 1);
    rstn = 1'b0; enable = 1'b0;
    tick();
    rstn = 1'b1;
    check("rstmid_valid", tx_valid, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_words", words_sent, 0);
    r0 = rd_count;
    tick();
    tick();
    check("rstmid_no_rd", rd_count - r0, 0);
    check("rstmid_fifo_left", fifo_q.size(), 1);
    enable = 1'b1;
    run_until_idle(60, 1'b0);
    check("rstmid_resume_rd", rd_count - r0, 1);
    check("rstmid_resume_words", words_sent, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
